// File: rtl/rvlab_rstmgr.sv
// Lock-qualified reset sequencer: filters MMCM lock, then releases periph reset, then core reset.
// Optional debug core-only reset via `RVLAB_RSTMGR_NDMRESET_EN.
`timescale 1ns/1ps
module rvlab_rstmgr #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 16,
  parameter int STRETCH_CYCLES = 64,
  parameter int CORE_DELAY     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       ndmreset_i,
  input  logic       cause_clr_i,
  output logic       periph_rst_o,
  output logic       core_rst_o,
  output logic [2:0] rst_cause_o,
  output logic [1:0] state_o
);

  localparam int MAX_A   = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
  localparam int CNT_MAX = (MAX_A > CORE_DELAY) ? MAX_A : CORE_DELAY;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] LF_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] CD_LAST = CW'(CORE_DELAY - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STRETCH = 2'd1,
    S_PERIPH  = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cntNext;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_periphRst;
  logic                   r_coreRst;
  logic [2:0]             r_cause;
  logic                   w_lockedS;
  logic                   w_lockLoss;
  logic                   w_ndm;
  logic [2:0]             w_causeSet;

`ifdef RVLAB_RSTMGR_NDMRESET_EN
  assign w_ndm = ndmreset_i;
`else
  logic w_unusedNdm;
  assign w_unusedNdm = ndmreset_i;
  assign w_ndm       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign w_lockedS  = r_sync[SYNC_STAGES-1];
  // Losing lock in HOLD only restarts the filter; anywhere else it is a reset event.
  assign w_lockLoss = (r_state != S_HOLD) && !w_lockedS;
  assign w_causeSet = {w_ndm && !w_lockLoss, w_lockLoss, 1'b0};

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    if (w_lockLoss) begin
      w_stateNext = S_HOLD;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (!w_lockedS) begin
            w_cntNext = '0;
          end else if (r_cnt == LF_LAST) begin
            w_stateNext = S_STRETCH;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        S_STRETCH: begin
          if (r_cnt == ST_LAST) begin
            w_stateNext = S_PERIPH;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        S_PERIPH: begin
          if (w_ndm) begin
            w_cntNext = '0;
          end else if (r_cnt == CD_LAST) begin
            w_stateNext = S_RUN;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          w_cntNext = '0;
          if (w_ndm) begin
            w_stateNext = S_PERIPH;
          end
        end
        default: begin
          w_stateNext = S_HOLD;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_periphRst <= 1'b1;
      r_coreRst   <= 1'b1;
      r_cause     <= 3'b001;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_periphRst <= (w_stateNext == S_HOLD) || (w_stateNext == S_STRETCH);
      r_coreRst   <= (w_stateNext != S_RUN);
      r_cause     <= (cause_clr_i ? 3'b000 : r_cause) | w_causeSet;
    end
  end

  assign periph_rst_o = r_periphRst;
  assign core_rst_o   = r_coreRst;
  assign rst_cause_o  = r_cause;
  assign state_o      = r_state;

endmodule

// File: tb/tb_rvlab_rstmgr.sv
// Self-checking bench for rvlab_rstmgr: directed release/lock-loss/ndmreset/cause scenarios
// plus randomized stimulus, all compared against a timeline model of the reset sequence.
`timescale 1ns/1ps
module tb_rvlab_rstmgr;

  localparam int SYNC_STAGES    = 2;
  localparam int LOCK_FILTER    = 16;
  localparam int STRETCH_CYCLES = 64;
  localparam int CORE_DELAY     = 16;

`ifdef RVLAB_RSTMGR_NDMRESET_EN
  localparam bit NDM_EN = 1'b1;
`else
  localparam bit NDM_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       locked;
  logic       ndmreset;
  logic       causeClr;
  logic       periphRst;
  logic       coreRst;
  logic [2:0] rstCause;
  logic [1:0] stateOut;

  int assertCount = 0;
  int failCount   = 0;

  // Model: lock history, whether we are still waiting on the filter, and elapsed-time counters.
  bit         mHist [SYNC_STAGES];
  bit         mWaiting;
  int         mRun;
  int         mSince;
  int         mCore;
  logic [2:0] mCause;

  rvlab_rstmgr #(
    .SYNC_STAGES   (SYNC_STAGES),
    .LOCK_FILTER   (LOCK_FILTER),
    .STRETCH_CYCLES(STRETCH_CYCLES),
    .CORE_DELAY    (CORE_DELAY)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .locked_i    (locked),
    .ndmreset_i  (ndmreset),
    .cause_clr_i (causeClr),
    .periph_rst_o(periphRst),
    .core_rst_o  (coreRst),
    .rst_cause_o (rstCause),
    .state_o     (stateOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit lk, input bit ndm, input bit clr);
    bit lockedS;
    bit ndmEff;
    bit loss;
    if (r) begin
      for (int i = 0; i < SYNC_STAGES; i++) mHist[i] = 1'b0;
      mWaiting = 1'b1;
      mRun     = 0;
      mSince   = 0;
      mCore    = 0;
      mCause   = 3'b001;
      return;
    end
    lockedS = mHist[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = lk;
    ndmEff = NDM_EN && ndm;
    loss   = !mWaiting && !lockedS;
    mCause = (clr ? 3'b000 : mCause) | {ndmEff && !loss, loss, 1'b0};
    if (mWaiting) begin
      if (lockedS) begin
        mRun++;
        if (mRun == LOCK_FILTER) begin
          mWaiting = 1'b0;
          mSince   = 0;
          mCore    = 0;
        end
      end else begin
        mRun = 0;
      end
    end else if (loss) begin
      mWaiting = 1'b1;
      mRun     = 0;
    end else if (mSince < STRETCH_CYCLES) begin
      mSince++;
    end else if (ndmEff) begin
      mCore = 0;
    end else if (mCore < CORE_DELAY) begin
      mCore++;
    end
  endtask

  task automatic compareAll();
    bit   expPeriph;
    bit   expCore;
    logic [1:0] expState;
    expPeriph = mWaiting || (mSince < STRETCH_CYCLES);
    expCore   = expPeriph || (mCore < CORE_DELAY);
    expState  = mWaiting ? 2'd0 : (mSince < STRETCH_CYCLES) ? 2'd1 : (mCore < CORE_DELAY) ? 2'd2 : 2'd3;
    checkOutput("periphRst", 8'(periphRst), 8'(expPeriph));
    checkOutput("coreRst",   8'(coreRst),   8'(expCore));
    checkOutput("rstCause",  8'(rstCause),  8'(mCause));
    checkOutput("state",     8'(stateOut),  8'(expState));
  endtask

  task automatic applyStimulus(input bit r, input bit lk, input bit ndm, input bit clr);
    rst      = r;
    locked   = lk;
    ndmreset = ndm;
    causeClr = clr;
    @(posedge clk);
    modelStep(r, lk, ndm, clr);
    #1;
    compareAll();
  endtask

  task automatic runLocked(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int relP;
    int relC;
    int n;
    int lockDown;
    int ndmLeft;
    bit r;
    bit clr;

    rst = 1'b1; locked = 1'b1; ndmreset = 1'b0; causeClr = 1'b0;
    #2;

    // Nominal release timing from reset with lock stable.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    relP = 0;
    relC = 0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (!periphRst && relP == 0) relP = cyc;
      if (!coreRst && relC == 0) relC = cyc;
    end
    checkOutput("periphReleaseCycle", 8'(relP), 8'(SYNC_STAGES + LOCK_FILTER + STRETCH_CYCLES));
    checkOutput("coreReleaseCycle",   8'(relC), 8'(SYNC_STAGES + LOCK_FILTER + STRETCH_CYCLES + CORE_DELAY));
    checkOutput("nominalCause", 8'(rstCause), 8'h01);
    checkOutput("nominalState", 8'(stateOut), 8'h03);

    // Aborted lock attempt restarts the filter.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    relP = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (!periphRst && relP == 0) relP = cyc;
    end
    checkOutput("refilterRelease", 8'(relP), 8'(SYNC_STAGES + LOCK_FILTER + STRETCH_CYCLES));

    // One-cycle lock drop while running.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (!periphRst && n < 10) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("lossLatency", 8'(n), 8'(SYNC_STAGES + 1));
    checkOutput("lossCoreRst", 8'(coreRst), 8'h01);
    checkOutput("lossState", 8'(stateOut), 8'h00);
    checkOutput("lossCauseBit", 8'(rstCause[1]), 8'h01);
    runLocked(110);

    // Cause clear, then clear coinciding with a lock-loss edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("causeCleared", 8'(rstCause), 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("clrVsLoss", 8'(rstCause), 8'h02);
    runLocked(110);

    // Debug core-only reset while running.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("ndmCoreNext", 8'(coreRst), 8'(NDM_EN));
    checkOutput("ndmPeriphKept", 8'(periphRst), 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (coreRst && n < 40) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("ndmCoreRelease", 8'(n), NDM_EN ? 8'(CORE_DELAY) : 8'h00);
    checkOutput("ndmCauseBit", 8'(rstCause[2]), 8'(NDM_EN));

    // External reset arriving mid-sequence.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runLocked(85);
    checkOutput("inPeriphState", 8'(stateOut), 8'h02);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rstMidState", 8'(stateOut), 8'h00);
    checkOutput("rstMidPeriph", 8'(periphRst), 8'h01);
    checkOutput("rstMidCause", 8'(rstCause), 8'h01);

    // Randomized stimulus.
    lockDown = 0;
    ndmLeft  = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (lockDown == 0 && $urandom_range(0, 299) == 0) lockDown = $urandom_range(1, 4);
      else if (lockDown > 0) lockDown--;
      if (ndmLeft == 0 && $urandom_range(0, 79) == 0) ndmLeft = $urandom_range(1, 6);
      else if (ndmLeft > 0) ndmLeft--;
      r   = ($urandom_range(0, 999) == 0);
      clr = ($urandom_range(0, 39) == 0);
      applyStimulus(r, lockDown == 0, ndmLeft != 0, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rvlab_rstmgr.md
Name: rvlab_rstmgr

Overview:
- Reset sequencer directly downstream of the clock manager. Consumes the MMCM lock indication and produces staged, lock-qualified resets for the system.
- Runs on the free-running buffered 100 MHz clock, which keeps toggling while the MMCM is unlocked.
- Releases the peripheral reset first, then the core reset after a further delay.
- Re-enters reset on lock loss, on external reset, and (optionally) on a debug-module core-only reset request. Latches the reset cause.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for locked_i (minimum 2).
- LOCK_FILTER, 16: consecutive cycles synchronized lock must be high before sequencing starts (minimum 1).
- STRETCH_CYCLES, 64: cycles both resets stay asserted after the lock filter passes (minimum 1).
- CORE_DELAY, 16: cycles between peripheral release and core release (minimum 1).

Ports:
- clk_i, input, 1: free-running buffered 100 MHz clock.
- rst_i, input, 1: reset; synchronous, active-high.
- locked_i, input, 1: MMCM lock, asynchronous to clk_i.
- ndmreset_i, input, 1: debug-module core reset request, synchronous to clk_i.
- cause_clr_i, input, 1: single-cycle pulse that clears rst_cause_o.
- periph_rst_o, output, 1: peripheral/interconnect reset, active-high, registered.
- core_rst_o, output, 1: CPU core reset, active-high, registered.
- rst_cause_o, output, 3: sticky cause flags. [0] external rst_i, [1] lock loss, [2] ndmreset.
- state_o, output, 2: current FSM state, for debug/status.

Behaviour:
- Reset is synchronous and active-high on rst_i, sampled on the rising edge of clk_i.
- Reset values:
  - periph_rst_o = 1, core_rst_o = 1.
  - rst_cause_o = 3'b001.
  - state = S_HOLD (state_o = 2'd0).
  - synchronizer flops = 0; all counters = 0.
- locked_s is locked_i passed through SYNC_STAGES flops. No other path uses locked_i.
- Single shared counter cnt, width $clog2(max(LOCK_FILTER, STRETCH_CYCLES, CORE_DELAY)) + 1.
  - Cleared on every state transition.
  - Never wraps: each state leaves or holds at its terminal value.
- Output encoding: outputs are registered from the next state.
  - S_HOLD, S_STRETCH: periph_rst_o = 1, core_rst_o = 1.
  - S_PERIPH: periph_rst_o = 0, core_rst_o = 1.
  - S_RUN: periph_rst_o = 0, core_rst_o = 0.
- FSM states and transitions:
  - S_HOLD (0): if locked_s = 1, cnt increments; if locked_s = 0, cnt clears. When cnt == LOCK_FILTER-1 and locked_s = 1, go to S_STRETCH.
  - S_STRETCH (1): cnt increments. When cnt == STRETCH_CYCLES-1, go to S_PERIPH.
  - S_PERIPH (2): cnt increments while ndmreset is inactive; cnt is held at 0 while ndmreset is active. When cnt == CORE_DELAY-1 and ndmreset is inactive, go to S_RUN.
  - S_RUN (3): if ndmreset is active, go to S_PERIPH. core_rst_o reasserts on that edge; periph_rst_o stays 0.
- Lock loss: locked_s = 0 in any state other than S_HOLD sends the FSM to S_HOLD next edge. Both resets reassert on that edge and rst_cause_o[1] is set.
- Priority on the same edge, highest first: rst_i, then lock loss, then ndmreset, then cause_clr_i.
  - Lock loss together with ndmreset sets only bit 1.
  - A set event in the same cycle as cause_clr_i wins: the bit ends up set.
- Cause flags are sticky; cause_clr_i clears all three bits.
- rst_i mid-sequence returns every register to its reset value in one cycle.
- Nominal release time, with locked_i high throughout and counted from the first edge sampling rst_i = 0:
  - periph_rst_o falls after SYNC_STAGES + LOCK_FILTER + STRETCH_CYCLES = 82 cycles.
  - core_rst_o falls CORE_DELAY = 16 cycles later, at cycle 98.
- Consumers in the sys_clk domain apply their own release synchronizer. STRETCH_CYCLES guarantees sys_clk is running before release.

Optional Feature:
- Macro: RVLAB_RSTMGR_NDMRESET_EN.
- Defined: ndmreset_i is honoured as described above and sets rst_cause_o[2].
- Undefined:
  - The ndmreset_i port still exists but is ignored (internal ndmreset tied to 0).
  - S_RUN is left only on rst_i or lock loss.
  - rst_cause_o[2] is constant 0.

Test Plan:
- rst_i high for 5 cycles, then low; locked_i high throughout -> periph_rst_o falls at cycle 82, core_rst_o at cycle 98; rst_cause_o = 3'b001; state_o ends at 3.
- locked_i pulses high for 10 cycles, low for 3, then stays high -> filter restarts; periph_rst_o release is delayed by the aborted attempt and occurs 82 cycles after the final rise (plus sync latency already included).
- In S_RUN, drop locked_i for 1 cycle -> within SYNC_STAGES + 1 cycles both resets are 1, state_o = 0, rst_cause_o[1] = 1; full sequence repeats after relock.
- Macro defined: ndmreset_i high for 4 cycles in S_RUN -> core_rst_o = 1 next edge while periph_rst_o stays 0; core_rst_o falls 16 cycles after ndmreset_i falls; rst_cause_o[2] = 1. Macro undefined: same stimulus produces no change.
- cause_clr_i pulse -> rst_cause_o = 0. cause_clr_i on the same edge as a lock-loss event -> rst_cause_o = 3'b010.
- rst_i asserted in S_PERIPH -> next edge: both resets 1, state_o = 0, rst_cause_o = 3'b001.
